// File: rtl/seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
//
// Converts six captured seven-segment patterns (active-low {dp,g,f,e,d,c,b,a})
// into a 20-bit binary value. One digit is consumed per clock, most
// significant first, so a result is always ready a fixed number of cycles
// after start is accepted.
//
// Configuration macro: SEVEN_SEG_DECODER_BLANK_EN
//   defined   : an all-segments-off digit (bits 6:0 = 7F) decodes as 0
//   undefined : an all-segments-off digit is an invalid digit
//
// Ports
//   clock      in   1  rising-edge clock
//   reset_n    in   1  synchronous active-low reset
//   start      in   1  capture dig5..dig0 and begin a decode (IDLE/DONE only)
//   dig5..dig0 in   8  segment patterns, dig5 most significant
//   busy       out  1  high while digits are being decoded
//   valid      out  1  one-cycle pulse marking a new result
//   value      out 20  decoded value (0 when error is set)
//   error      out  1  the last result contained an invalid digit
//   err_digit  out  3  index of the most significant invalid digit
// -----------------------------------------------------------------------------
module seven_seg_decoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  dig5,
  input  logic [7:0]  dig4,
  input  logic [7:0]  dig3,
  input  logic [7:0]  dig2,
  input  logic [7:0]  dig1,
  input  logic [7:0]  dig0,
  output logic        busy,
  output logic        valid,
  output logic [19:0] value,
  output logic        error,
  output logic [2:0]  err_digit
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] num;
  } seg_t;

  // The dp bit is a wildcard in every pattern, so it never affects matching.
  function automatic seg_t decode_seg(input logic [7:0] pat);
    seg_t r;
    r = '{ok: 1'b1, num: 4'd0};
    casez (pat)
      8'b?1000000: r.num = 4'd0;
      8'b?1111001: r.num = 4'd1;
      8'b?0100100: r.num = 4'd2;
      8'b?0110000: r.num = 4'd3;
      8'b?0011001: r.num = 4'd4;
      8'b?0010010: r.num = 4'd5;
      8'b?0000010: r.num = 4'd6;
      8'b?1111000: r.num = 4'd7;
      8'b?0000000: r.num = 4'd8;
      8'b?0010000: r.num = 4'd9;
`ifdef SEVEN_SEG_DECODER_BLANK_EN
      8'b?1111111: r.num = 4'd0;   // blank digit, for leading-blank displays
`endif
      default:     r.ok  = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state;
  logic [5:0][7:0]  digs;      // captured patterns, digs[5] is most significant
  logic [2:0]       idx;       // digit being decoded, counts 5 down to 0
  logic [19:0]      acc;
  logic             err_flag;
  logic [2:0]       err_pos;

  seg_t             cur;
  logic [19:0]      acc_next;
  logic             err_next;
  logic [2:0]       pos_next;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    cur      = decode_seg(digs[idx]);
    acc_next = (acc * 20'd10) + {16'd0, cur.num};
    err_next = err_flag | ~cur.ok;
    pos_next = err_pos;
    // Only the first invalid digit seen (the most significant one) is kept.
    if (!cur.ok && !err_flag) begin
      pos_next = idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      value     <= 20'd0;
      error     <= 1'b0;
      err_digit <= 3'd0;
      idx       <= 3'd0;
      acc       <= 20'd0;
      err_flag  <= 1'b0;
      err_pos   <= 3'd0;
      // NOTE: the captured digit registers are deliberately not reset; they
      // are always reloaded on start before being read.
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          if (start) begin
            digs     <= {dig5, dig4, dig3, dig2, dig1, dig0};
            idx      <= 3'd5;
            acc      <= 20'd0;
            err_flag <= 1'b0;
            err_pos  <= 3'd0;
            busy     <= 1'b1;
            state    <= DECODE;
          end else begin
            state    <= IDLE;
          end
        end

        DECODE: begin
          // start is ignored here; decoding continues past invalid digits
          // so the latency never changes.
          acc      <= acc_next;
          err_flag <= err_next;
          err_pos  <= pos_next;
          if (idx == 3'd0) begin
            state     <= DONE;
            busy      <= 1'b0;
            valid     <= 1'b1;
            value     <= err_next ? 20'd0 : acc_next;
            error     <= err_next;
            err_digit <= err_next ? pos_next : 3'd0;
          end else begin
            idx <= idx - 3'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seven_seg_decoder.md
SEVEN_SEG_DECODER -- requirements
Module: seven_seg_decoder

Interface
REQ-001 SHALL have no parameters; the block is fixed at six digits and a 20-bit result.
REQ-002 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to decode the current digit inputs.
REQ-005 SHALL have ports dig5..dig0, input, 8 each, segment patterns with dig5 as the most significant digit.
REQ-006 SHALL have port busy, output, 1, high while a decode is in progress.
REQ-007 SHALL have port valid, output, 1, a one-cycle pulse marking a result.
REQ-008 SHALL have port value, output, 20, the decoded binary value.
REQ-009 SHALL have port error, output, 1, set when the last result contained an invalid digit.
REQ-010 SHALL have port err_digit, output, 3, the index (0-5) of the most significant invalid digit.

Function
REQ-011 SHALL use the active-low pattern {dp,g,f,e,d,c,b,a} and ignore bit 7 (dp) when matching.
REQ-012 SHALL match bits 6:0 as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-013 SHALL treat any other bits 6:0 pattern as an invalid digit.
REQ-014 SHALL implement the FSM IDLE -> DECODE -> DONE.
REQ-015 In IDLE or DONE, start=1 SHALL capture all six dig inputs into registers, clear the accumulator and the error state, and enter DECODE.
REQ-016 In DECODE, SHALL process one captured digit per clock in the order dig5 to dig0, computing acc = acc*10 + d with a 20-bit accumulator.
REQ-017 The worst case, 999999, SHALL fit the 20-bit accumulator with no overflow handling.
REQ-018 After the sixth digit, the FSM SHALL enter DONE.
REQ-019 DONE SHALL last one cycle; valid=1 during it; the FSM then returns to IDLE unless start=1.
REQ-020 Latency SHALL be fixed: valid asserts in the 7th cycle after the edge that samples start.
REQ-021 busy SHALL be 1 exactly while in DECODE.
REQ-022 start SHALL be ignored while in DECODE.
REQ-023 Changes on dig inputs after capture SHALL have no effect on the result.
REQ-024 On an invalid digit, SHALL set error and latch err_digit on the first (most significant) occurrence only.
REQ-025 Decoding SHALL continue after an invalid digit so that latency stays fixed.
REQ-026 When error=1, value SHALL be 0 at valid.
REQ-027 value, error and err_digit SHALL update only in the cycle valid rises and hold until the next valid.
REQ-028 start in DONE SHALL begin a new decode back-to-back; valid still pulses for exactly one cycle.

Reset
REQ-029 reset_n=0 at a rising edge SHALL force IDLE and busy=0, valid=0, value=0, error=0, err_digit=0.
REQ-030 Reset SHALL override start.
REQ-031 Reset during DECODE SHALL abort the decode and produce no valid pulse.
REQ-032 The first start accepted after reset is released SHALL decode normally.

Configuration
REQ-033 Macro SEVEN_SEG_DECODER_BLANK_EN SHALL select how an all-segments-off digit (bits 6:0 = 7F) is handled.
REQ-034 With SEVEN_SEG_DECODER_BLANK_EN defined, a 7F digit SHALL decode as 0 without setting error, supporting leading-blank displays.
REQ-035 Without SEVEN_SEG_DECODER_BLANK_EN, a 7F digit SHALL be treated as an invalid digit.

Verification
REQ-036 dig5..dig0 = F9,A4,B0,99,92,82, then start pulse -> busy for 6 cycles, then valid for 1 cycle, value=123456 (0x1E240), error=0.
REQ-037 All six digits = 90 -> value=999999 (0xF423F), error=0.
REQ-038 dig0=40 with dp lit, all other digits C0 -> value=0, error=0.
REQ-039 dig4=FF and dig2=33, others C0, macro undefined -> error=1, err_digit=4, value=0, valid still on the 7th cycle.
REQ-040 FF,FF,FF,FF,F9,A4 with macro defined -> value=12, error=0; the same input with macro undefined -> error=1, err_digit=5.
REQ-041 Assert reset_n=0 for one cycle, 3 cycles into a decode -> no valid pulse; all outputs 0 on the next cycle; a following start of 123456 decodes correctly.
